id_ex_issue: RTL and testbench
==============================

Name: id_ex_issue

Overview:
- Decode-and-issue stage register between ID and EX of the five-stage MIPS pipeline.
- Decodes the D-stage instruction into the ALU operation code, operands and downstream write controls, then registers them into the ID/EX boundary.
- Its outputs drive the EX-stage ALU (A, B, 3-bit op) and travel on to MEM/WB.
- Supports pipeline hold (freeze) and flush (bubble insertion).

Parameters:
- RESET_PC, 32'h00003000, value loaded into E_PC on reset and on bubble insertion.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- D_Instr  input  32  instruction in ID.
- D_PC  input  32  PC of D_Instr.
- D_RS_Data  input  32  rs value, already forwarded in ID.
- D_RT_Data  input  32  rt value, already forwarded in ID.
- hold  input  1  freeze all E registers this edge.
- flush  input  1  load a bubble instead of D-stage contents.
- E_Instr  output  32  registered instruction.
- E_PC  output  32  registered PC.
- E_A  output  32  ALU operand A.
- E_B  output  32  ALU operand B.
- E_ALUOp  output  3  000 and, 001 or, 010 add, 011 sub.
- E_RT_Data  output  32  store data.
- E_A3  output  5  destination register.
- E_RegWrite  output  1  register-file write enable.
- E_MemWrite  output  1  data-memory write enable.
- E_MemToReg  output  1  WB selects memory data.
- E_Valid  output  1  stage holds a real (non-bubble) instruction.

Behaviour:
- Clock and reset: all outputs are registered; one clock, rising edge.
- Reset (async, active-high), applied immediately regardless of clk:
  - E_PC = RESET_PC.
  - Every other output = 0. This is a bubble: ALUOp 000, no writes.
- Per-edge priority: reset > hold > flush > load.
  - hold=1: every register keeps its value, even if flush=1 in the same cycle.
  - flush=1 with hold=0: load a bubble (same values as reset, E_Valid=0).
  - Otherwise: load the decode of the D-stage inputs, with E_Valid=1.
  - Latency: one cycle from D inputs to E outputs.
- Decode uses op = Instr[31:26] and funct = Instr[5:0]:
  - addu (op 0, funct 100001): op 010, A=rs, B=rt, A3=rd, RegWrite.
  - subu (op 0, funct 100011): op 011, A=rs, B=rt, A3=rd, RegWrite.
  - and (op 0, funct 100100): op 000, A=rs, B=rt, A3=rd, RegWrite.
  - or (op 0, funct 100101): op 001, A=rs, B=rt, A3=rd, RegWrite.
  - ori (op 001101): op 001, A=rs, B=zero-extended imm16, A3=rt, RegWrite.
  - lui (op 001111): op 001, A=0, B={imm16,16'h0}, A3=rt, RegWrite.
  - lw (op 100011): op 010, A=rs, B=sign-extended imm16, A3=rt, RegWrite, MemToReg.
  - sw (op 101011): op 010, A=rs, B=sign-extended imm16, MemWrite.
  - jal (op 000011): op 010, A=D_PC, B=32'd8, A3=31, RegWrite.
- All other encodings (beq, j, jr, sll-nop, unknown): op 000, A=0, B=0, A3=0, no writes. E_Valid is still 1 on a normal load.
- E_RT_Data = D_RT_Data for every loaded instruction.
- Destination $0: if the decoded A3=0, E_RegWrite is forced to 0.
- Whenever E_RegWrite=0, E_A3 is driven as 0.
- Arithmetic: 32-bit. Sign extension replicates imm16[15]. jal link value is computed downstream by the ALU (A+B), not in this block.
- Reset mid-operation: the bubble state appears immediately and asynchronously.
- After reset deasserts, the first rising edge loads normally unless hold or flush is asserted.

Test Plan:
- Reset: assert reset between edges.
  - Outputs go to 0 at once, E_PC=32'h00003000, no clock needed.
- addu: D_Instr=32'h00853021 (addu $6,$4,$5), RS=5, RT=7.
  - Next edge: E_A=5, E_B=7, E_ALUOp=010, E_A3=6, E_RegWrite=1, E_Valid=1.
- lui and lw:
  - D_Instr=32'h3C01ABCD → E_A=0, E_B=32'hABCD0000, E_ALUOp=001, E_A3=1.
  - lw with imm 16'hFFFC → E_B=32'hFFFFFFFC, E_MemToReg=1.
- jal: D_PC=32'h00003010, D_Instr=32'h0C000C10.
  - E_A=32'h00003010, E_B=8, E_ALUOp=010, E_A3=31, E_RegWrite=1.
- hold/flush priority:
  - Load addu.
  - Assert hold and flush together for 2 edges → outputs unchanged.
  - Deassert hold with flush=1 → bubble, E_Valid=0, E_RegWrite=0.
- $0 destination and sw: ori $0,$1,5 → E_RegWrite=0, E_A3=0; sw → E_MemWrite=1, E_RegWrite=0, E_RT_Data=D_RT_Data.

Source files
------------

// File: rtl/id_ex_issue.sv
// ID/EX decode-and-issue register for the five-stage MIPS pipeline.
// Ports: clk/reset, D-stage instr/pc/rs/rt in, hold/flush, E-stage bundle out.
module id_ex_issue #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_RS_Data,
  input  logic [31:0] D_RT_Data,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] E_Instr,
  output logic [31:0] E_PC,
  output logic [31:0] E_A,
  output logic [31:0] E_B,
  output logic [2:0]  E_ALUOp,
  output logic [31:0] E_RT_Data,
  output logic [4:0]  E_A3,
  output logic        E_RegWrite,
  output logic        E_MemWrite,
  output logic        E_MemToReg,
  output logic        E_Valid
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_op;
    logic [31:0] rt_data;
    logic [4:0]  a3;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        valid;
  } id_ex_t;

  // Bubble: no writes, ALU op AND, PC parked at the reset vector.
  localparam id_ex_t BUBBLE = id_ex_t'({32'h0, RESET_PC, 108'h0});

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [15:0] imm;
  logic [31:0] imm_zext;
  logic [31:0] imm_sext;
  logic [31:0] imm_lui;

  assign op       = D_Instr[31:26];
  assign funct    = D_Instr[5:0];
  assign rt_f     = D_Instr[20:16];
  assign rd_f     = D_Instr[15:11];
  assign imm      = D_Instr[15:0];
  assign imm_zext = {16'h0, imm};
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_lui  = {imm, 16'h0};

  logic is_r;
  logic is_addu;
  logic is_subu;
  logic is_and;
  logic is_or;
  logic is_ori;
  logic is_lui;
  logic is_lw;
  logic is_sw;
  logic is_jal;

  assign is_r    = (op == OP_RTYPE);
  assign is_addu = is_r && (funct == FN_ADDU);
  assign is_subu = is_r && (funct == FN_SUBU);
  assign is_and  = is_r && (funct == FN_AND);
  assign is_or   = is_r && (funct == FN_OR);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_jal  = (op == OP_JAL);

  logic [2:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_a3;
  logic        dec_rw;
  logic        dec_mw;
  logic        dec_m2r;

  always_comb begin
    dec_op  = ALU_AND;
    dec_a   = 32'h0;
    dec_b   = 32'h0;
    dec_a3  = 5'd0;
    dec_rw  = 1'b0;
    dec_mw  = 1'b0;
    dec_m2r = 1'b0;
    unique case (1'b1)
      is_addu: begin
        dec_op = ALU_ADD;
        dec_a  = D_RS_Data;
        dec_b  = D_RT_Data;
        dec_a3 = rd_f;
        dec_rw = 1'b1;
      end
      is_subu: begin
        dec_op = ALU_SUB;
        dec_a  = D_RS_Data;
        dec_b  = D_RT_Data;
        dec_a3 = rd_f;
        dec_rw = 1'b1;
      end
      is_and: begin
        dec_op = ALU_AND;
        dec_a  = D_RS_Data;
        dec_b  = D_RT_Data;
        dec_a3 = rd_f;
        dec_rw = 1'b1;
      end
      is_or: begin
        dec_op = ALU_OR;
        dec_a  = D_RS_Data;
        dec_b  = D_RT_Data;
        dec_a3 = rd_f;
        dec_rw = 1'b1;
      end
      is_ori: begin
        dec_op = ALU_OR;
        dec_a  = D_RS_Data;
        dec_b  = imm_zext;
        dec_a3 = rt_f;
        dec_rw = 1'b1;
      end
      is_lui: begin
        dec_op = ALU_OR;
        dec_b  = imm_lui;
        dec_a3 = rt_f;
        dec_rw = 1'b1;
      end
      is_lw: begin
        dec_op  = ALU_ADD;
        dec_a   = D_RS_Data;
        dec_b   = imm_sext;
        dec_a3  = rt_f;
        dec_rw  = 1'b1;
        dec_m2r = 1'b1;
      end
      is_sw: begin
        dec_op = ALU_ADD;
        dec_a  = D_RS_Data;
        dec_b  = imm_sext;
        dec_mw = 1'b1;
      end
      is_jal: begin
        // Link address PC+8 is formed by the EX adder.
        dec_op = ALU_ADD;
        dec_a  = D_PC;
        dec_b  = 32'd8;
        dec_a3 = 5'd31;
        dec_rw = 1'b1;
      end
      default: ;
    endcase
  end

  id_ex_t load;
  logic   load_rw;

  // Writes to $0 are dropped, and A3 reads 0 whenever nothing is written.
  assign load_rw = dec_rw && (dec_a3 != 5'd0);

  always_comb begin
    load            = BUBBLE;
    load.instr      = D_Instr;
    load.pc         = D_PC;
    load.a          = dec_a;
    load.b          = dec_b;
    load.alu_op     = dec_op;
    load.rt_data    = D_RT_Data;
    load.a3         = load_rw ? dec_a3 : 5'd0;
    load.reg_write  = load_rw;
    load.mem_write  = dec_mw;
    load.mem_to_reg = dec_m2r;
    load.valid      = 1'b1;
  end

  id_ex_t e_d;
  id_ex_t e_q;

  // hold wins over flush; flush wins over a normal load.
  always_comb begin
    e_d = e_q;
    if (!hold) begin
      e_d = flush ? BUBBLE : load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  assign E_Instr    = e_q.instr;
  assign E_PC       = e_q.pc;
  assign E_A        = e_q.a;
  assign E_B        = e_q.b;
  assign E_ALUOp    = e_q.alu_op;
  assign E_RT_Data  = e_q.rt_data;
  assign E_A3       = e_q.a3;
  assign E_RegWrite = e_q.reg_write;
  assign E_MemWrite = e_q.mem_write;
  assign E_MemToReg = e_q.mem_to_reg;
  assign E_Valid    = e_q.valid;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed scoreboard bench for id_ex_issue.
// Expected E bundles are queued at drive time and checked after each edge.
module tb_id_ex_issue;

  logic        clk;
  logic        reset;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic [31:0] D_RS_Data;
  logic [31:0] D_RT_Data;
  logic        hold;
  logic        flush;
  logic [31:0] E_Instr;
  logic [31:0] E_PC;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic [2:0]  E_ALUOp;
  logic [31:0] E_RT_Data;
  logic [4:0]  E_A3;
  logic        E_RegWrite;
  logic        E_MemWrite;
  logic        E_MemToReg;
  logic        E_Valid;

  id_ex_issue #(.RESET_PC(32'h00003000)) dut (
    .clk(clk),
    .reset(reset),
    .D_Instr(D_Instr),
    .D_PC(D_PC),
    .D_RS_Data(D_RS_Data),
    .D_RT_Data(D_RT_Data),
    .hold(hold),
    .flush(flush),
    .E_Instr(E_Instr),
    .E_PC(E_PC),
    .E_A(E_A),
    .E_B(E_B),
    .E_ALUOp(E_ALUOp),
    .E_RT_Data(E_RT_Data),
    .E_A3(E_A3),
    .E_RegWrite(E_RegWrite),
    .E_MemWrite(E_MemWrite),
    .E_MemToReg(E_MemToReg),
    .E_Valid(E_Valid)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] rtd;
    logic [4:0]  a3;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [31:0] instr, pc, a, b,
    input logic [2:0]  op,
    input logic [31:0] rtd,
    input logic [4:0]  a3,
    input logic        rw, mw, m2r, v
  );
    exp_t e;
    e = {instr, pc, a, b, op, rtd, a3, rw, mw, m2r, v};
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t obs;
    exp_t e;
    obs = {E_Instr, E_PC, E_A, E_B, E_ALUOp, E_RT_Data, E_A3,
           E_RegWrite, E_MemWrite, E_MemToReg, E_Valid};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic step(
    input string       tag,
    input logic [31:0] instr, pc, rs, rt,
    input logic        h, f,
    input exp_t        e
  );
    @(negedge clk);
    D_Instr   = instr;
    D_PC      = pc;
    D_RS_Data = rs;
    D_RT_Data = rt;
    hold      = h;
    flush     = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  exp_t bub;
  exp_t addu2;

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    D_Instr   = 32'h0;
    D_PC      = 32'h0;
    D_RS_Data = 32'h0;
    D_RT_Data = 32'h0;
    hold      = 1'b0;
    flush     = 1'b0;
    bub = mk(32'h0, 32'h3000, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b0);

    #2 reset = 1'b1;
    #1;
    sb.push_back(bub);
    check_out("reset_async");
    @(posedge clk);
    #1;
    sb.push_back(bub);
    check_out("reset_held");
    @(negedge clk);
    reset = 1'b0;

    step("addu", 32'h00853021, 32'h3000, 32'd5, 32'd7, 1'b0, 1'b0,
         mk(32'h00853021, 32'h3000, 32'd5, 32'd7, 3'b010, 32'd7,
            5'd6, 1'b1, 1'b0, 1'b0, 1'b1));
    step("lui", 32'h3C01ABCD, 32'h3004, 32'h1234, 32'h55, 1'b0, 1'b0,
         mk(32'h3C01ABCD, 32'h3004, 32'h0, 32'hABCD0000, 3'b001,
            32'h55, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    step("lw_neg", 32'h8C43FFFC, 32'h3008, 32'h1000, 32'h77, 1'b0, 1'b0,
         mk(32'h8C43FFFC, 32'h3008, 32'h1000, 32'hFFFFFFFC, 3'b010,
            32'h77, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1));
    step("jal", 32'h0C000C10, 32'h3010, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0,
         mk(32'h0C000C10, 32'h3010, 32'h3010, 32'd8, 3'b010,
            32'hBEEF, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1));
    step("subu", 32'h01093823, 32'h3014, 32'd10, 32'd3, 1'b0, 1'b0,
         mk(32'h01093823, 32'h3014, 32'd10, 32'd3, 3'b011, 32'd3,
            5'd7, 1'b1, 1'b0, 1'b0, 1'b1));
    step("and", 32'h00225024, 32'h3018, 32'hF0F0, 32'hFF00, 1'b0, 1'b0,
         mk(32'h00225024, 32'h3018, 32'hF0F0, 32'hFF00, 3'b000,
            32'hFF00, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1));
    step("or", 32'h00225825, 32'h301C, 32'hF0F0, 32'hFF00, 1'b0, 1'b0,
         mk(32'h00225825, 32'h301C, 32'hF0F0, 32'hFF00, 3'b001,
            32'hFF00, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1));
    step("ori_zext", 32'h34228001, 32'h3020, 32'h10000, 32'd1, 1'b0, 1'b0,
         mk(32'h34228001, 32'h3020, 32'h10000, 32'h00008001, 3'b001,
            32'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1));
    step("ori_r0", 32'h34200005, 32'h3024, 32'd9, 32'd4, 1'b0, 1'b0,
         mk(32'h34200005, 32'h3024, 32'd9, 32'd5, 3'b001, 32'd4,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("sw", 32'hAFA80010, 32'h3028, 32'h2000, 32'hCAFEF00D, 1'b0, 1'b0,
         mk(32'hAFA80010, 32'h3028, 32'h2000, 32'h10, 3'b010,
            32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    step("beq_other", 32'h10220004, 32'h302C, 32'd1, 32'd2, 1'b0, 1'b0,
         mk(32'h10220004, 32'h302C, 32'h0, 32'h0, 3'b000, 32'd2,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    step("addu_r0", 32'h00850021, 32'h3030, 32'd1, 32'd2, 1'b0, 1'b0,
         mk(32'h00850021, 32'h3030, 32'd1, 32'd2, 3'b010, 32'd2,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    addu2 = mk(32'h00853021, 32'h3034, 32'd5, 32'd7, 3'b010, 32'd7,
               5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step("addu_pre_hold", 32'h00853021, 32'h3034, 32'd5, 32'd7,
         1'b0, 1'b0, addu2);
    step("hold_flush_1", 32'h3C01ABCD, 32'h3038, 32'd1, 32'd2,
         1'b1, 1'b1, addu2);
    step("hold_flush_2", 32'h3C01ABCD, 32'h303C, 32'd3, 32'd4,
         1'b1, 1'b1, addu2);
    step("flush_bubble", 32'h3C01ABCD, 32'h3040, 32'd3, 32'd4,
         1'b0, 1'b1, bub);
    step("hold_bubble", 32'h00853021, 32'h3044, 32'd5, 32'd7,
         1'b1, 1'b0, bub);
    step("lw_after_flush", 32'h8C430004, 32'h3048, 32'h100, 32'h9,
         1'b0, 1'b0,
         mk(32'h8C430004, 32'h3048, 32'h100, 32'h4, 3'b010, 32'h9,
            5'd3, 1'b1, 1'b0, 1'b1, 1'b1));

    @(negedge clk);
    reset = 1'b1;
    #1;
    sb.push_back(bub);
    check_out("reset_mid");
    #2 reset = 1'b0;

    step("addu_after_reset", 32'h00853021, 32'h304C, 32'd11, 32'd22,
         1'b0, 1'b0,
         mk(32'h00853021, 32'h304C, 32'd11, 32'd22, 3'b010, 32'd22,
            5'd6, 1'b1, 1'b0, 1'b0, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
